md_issue_ctrl: RTL
==================

# md_issue_ctrl

Pipeline-side issue and interlock controller for the HI/LO multiply/divide unit (`muldivpart`). It sits in the execute stage and accepts decoded mult/div/mthi/mtlo/mfhi/mflo operations. It drives the unit's `used`/`Control`/`SrcA`/`SrcB` inputs from registers and tracks the unit's `busy` output. It stalls the execute stage until the unit is able to accept or return data.

## Interface
- `MUL_LAT`, default 5: unit busy cycles after a multiply issue; used only by the checker.
- `DIV_LAT`, default 10: unit busy cycles after a divide issue; used only by the checker.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high. The same reset drives the unit.
- `op_valid`  in  1  the E-stage instruction is valid.
- `op`  in  4  operation code:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu
  - 5 mthi, 6 mtlo, 7 mfhi, 8 mflo
  - 9..15 are treated as none.
- `src_a`, `src_b`  in  32  E-stage operands.
- `flush`  in  1  squashes the E-stage instruction this cycle.
- `md_busy`  in  1  `busy` output of the unit.
- `stall`  out  1  holds the E stage (combinational).
- `md_used`  out  1  registered one-cycle issue strobe to the unit.
- `md_ctrl`  out  3  registered `Control` code:
  - 1 signed mul, 2 unsigned mul, 3 signed div, 4 unsigned div, 5 write HI, 6 write LO.
- `md_srca`, `md_srcb`  out  32  registered operands.
- `hilo_sel`  out  1  combinational: 1 selects HI, 0 selects LO, for mfhi/mflo writeback.
- `md_err`  out  1  sticky latency-mismatch flag (see Configuration).

## Operation
- Request: `req = op_valid & ~flush & op in 1..8`. Issue ops are `op` 1..6; read ops are `op` 7..8.
- States: IDLE, ISSUE, BUSY. The state and every output reset to IDLE/0.
- `stall = op_valid & ~flush & op in 1..8 & (state != IDLE | md_busy)`.
- IDLE:
  - Issue op with `req` and `~md_busy`: register `md_ctrl = op`, `md_srca = src_a`, `md_srcb = src_b`; go to ISSUE. The instruction leaves E this cycle (`stall` = 0).
  - Read op with `~md_busy`: not stalled; `hilo_sel = (op == 7)`; the state is unchanged.
- ISSUE: `md_used` = 1 for exactly this cycle.
  - Next state is BUSY if `md_ctrl` is 1..4.
  - Next state is IDLE if `md_ctrl` is 5..6.
  - Any md request arriving in this cycle stalls.
- BUSY: `md_used` = 0. Stay while `md_busy` = 1; go to IDLE on the first cycle with `md_busy` = 0. Requests stall.
- Back-to-back issue: an issue op in E during the cycle BUSY→IDLE is still stalled that cycle. It is accepted in the following IDLE cycle.
- `md_srca`/`md_srcb`/`md_ctrl` hold their value outside ISSUE. `md_ctrl` is meaningful only when `md_used` = 1.
- Flush:
  - Flush blocks acceptance in IDLE.
  - Flush never cancels an op already in ISSUE or BUSY, because that instruction has left E.
- Reset mid-operation: IDLE next cycle, `md_used` = 0, checker cleared. Nothing is re-issued.
- Non-md ops (`op` 0, 9..15) never stall and never change state.

## Timing
- Accept edge T0 → ISSUE in cycle T1 (`md_used` high). The unit latches its result at the end of T1.
- Multiply: `md_busy` is high in T2..T6. BUSY is exited at the end of T7's first low-busy cycle (T7), so IDLE from T8.
- A dependent mflo in E from T1 stalls in T1..T7 and proceeds in T8.
- Divide: `md_busy` is high in T2..T11; IDLE from T13.
- mthi/mtlo: ISSUE in T1, IDLE in T2. A following mfhi stalls one cycle (T1) only.
- `stall` and `hilo_sel` are combinational from the current state, `md_busy`, `op`, `op_valid` and `flush`. All other outputs are registered.

## Configuration
- `MD_LAT_CHECK_EN` defined: a 4-bit counter loads `MUL_LAT` or `DIV_LAT` at the ISSUE→BUSY transition. In BUSY it checks each cycle:
  - `cnt > 0` requires `md_busy` = 1; the counter then decrements.
  - `cnt == 0` requires `md_busy` = 0.
  - Any violation sets `md_err` = 1, which stays set until reset.
- Not defined: no counter; `md_err` is tied to 0.
- FSM behaviour is identical in both builds.

## Test plan
- Reset, then mult with `src_a` = 0xFFFFFFFF, `src_b` = 2 → `md_used` in T1 with `md_ctrl` = 1; unit LO = 0xFFFFFFFE, HI = 0xFFFFFFFF.
- The next op is mflo → `stall` high T1..T7; accepted T8 with `hilo_sel` = 0.
- divu with 7, 2, followed by mfhi → `stall` high for 12 cycles; HI = 1 and LO = 3 afterwards.
- mthi with 0x12345678, then mfhi → `md_ctrl` = 5; one stall cycle; HI reads 0x12345678.
- mult accepted with `flush` = 1 → no ISSUE, `md_used` stays 0, state stays IDLE.
- Reset asserted in BUSY cycle T4 of a div → IDLE at T5, `stall` = 0 for a following mflo, and `md_err` = 0.
- With `MD_LAT_CHECK_EN` defined, force `md_busy` low in T4 of a mult → `md_err` = 1 and it stays set until reset.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// Issue and interlock controller for the HI/LO multiply/divide unit.
// Optional busy-latency checker enabled by defining MD_LAT_CHECK_EN.
module md_issue_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        flush_i,
    input  logic        md_busy_i,
    output logic        stall_o,
    output logic        md_used_o,
    output logic [2:0]  md_ctrl_o,
    output logic [31:0] md_srca_o,
    output logic [31:0] md_srcb_o,
    output logic        hilo_sel_o,
    output logic        md_err_o
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StBusy
    } state_e;

    state_e      state_q, state_d;
    logic        used_q, used_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] srca_q, srca_d;
    logic [31:0] srcb_q, srcb_d;

    logic is_issue_op;
    logic is_read_op;
    logic md_req;
    logic accept;
    logic ctrl_is_arith;

    assign is_issue_op   = (op_i >= 4'd1) && (op_i <= 4'd6);
    assign is_read_op    = (op_i == 4'd7) || (op_i == 4'd8);
    assign md_req        = op_valid_i && !flush_i && (is_issue_op || is_read_op);
    assign accept        = md_req && is_issue_op && (state_q == StIdle) && !md_busy_i;
    assign ctrl_is_arith = (ctrl_q >= 3'd1) && (ctrl_q <= 3'd4);

    // Any md request waits while the controller is not idle or the unit is busy.
    assign stall_o    = md_req && ((state_q != StIdle) || md_busy_i);
    assign hilo_sel_o = md_req && (op_i == 4'd7);

    always_comb begin
        state_d = state_q;
        used_d  = 1'b0;
        ctrl_d  = ctrl_q;
        srca_d  = srca_q;
        srcb_d  = srcb_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StIssue;
                    used_d  = 1'b1;
                    ctrl_d  = op_i[2:0];
                    srca_d  = src_a_i;
                    srcb_d  = src_b_i;
                end
            end
            StIssue: begin
                state_d = ctrl_is_arith ? StBusy : StIdle;
            end
            StBusy: begin
                if (!md_busy_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            used_q  <= 1'b0;
            ctrl_q  <= 3'd0;
            srca_q  <= 32'd0;
            srcb_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            used_q  <= used_d;
            ctrl_q  <= ctrl_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
        end
    end

    assign md_used_o = used_q;
    assign md_ctrl_o = ctrl_q;
    assign md_srca_o = srca_q;
    assign md_srcb_o = srcb_q;

`ifdef MD_LAT_CHECK_EN
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    // Counter expects exactly LAT busy cycles followed by one idle cycle.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if ((state_q == StIssue) && (state_d == StBusy)) begin
            cnt_d = (ctrl_q <= 3'd2) ? MUL_LAT[3:0] : DIV_LAT[3:0];
        end else if (state_q == StBusy) begin
            if (cnt_q != 4'd0) begin
                if (!md_busy_i) begin
                    err_d = 1'b1;
                end
                cnt_d = cnt_q - 4'd1;
            end else if (md_busy_i) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign md_err_o = err_q;
`else
    logic unused_lat_cfg;
    assign unused_lat_cfg = ^{MUL_LAT[3:0], DIV_LAT[3:0]};
    assign md_err_o       = 1'b0;
`endif

endmodule
